// File: rtl/scan_pkg.sv
// scan_pkg: shared constants and types for the digit scan controller
package scan_pkg;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam int NDIG = 4;
  localparam int NIB_W = 4;
  typedef logic [1:0] digit_idx_t;
  typedef enum logic {IDLE, PEND} shd_state_t;
endpackage

// File: rtl/dec24_n.sv
// dec24_n: combinational 2-to-4 decoder with active-low one-hot output
module dec24_n
  import scan_pkg::*;
(
  input  digit_idx_t w,
  output logic [3:0] y
);
  assign y = ~(4'b0001 << w);
endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: 4-digit common-anode scan controller with tear-free word updates
// Optional SCAN_GHOST_GUARD_EN blanks an_n for the first GUARD cycles of every slot.
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int DIV = 50000,
  parameter int GUARD = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [NDIG*NIB_W-1:0]   din,
  output logic                    ack,
  output logic [3:0]              an_n,
  output logic [NIB_W-1:0]        digit,
  output logic [1:0]              idx
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
`ifdef SCAN_GHOST_GUARD_EN
  localparam bit GUARD_ON = 1'b1;
`else
  localparam bit GUARD_ON = 1'b0;
`endif
  localparam logic [3:0] AN_RST = (GUARD_ON && GUARD > 0) ? AN_OFF : 4'b1110;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic w_tick, w_fe, w_ack_nxt, r_ack;
  digit_idx_t r_idx, w_idx_nxt;
  logic [3:0] w_dec, w_an_nxt, r_an_n;
  logic [NIB_W-1:0] r_digit;
  logic [NDIG*NIB_W-1:0] r_disp, w_disp_nxt, r_pw, w_pw_nxt;
  shd_state_t r_state, w_state_nxt;
  assign w_tick = r_cnt == CW'(DIV - 1);
  assign w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
  assign w_idx_nxt = w_tick ? r_idx + 2'd1 : r_idx;
  assign w_fe = w_tick && r_idx == 2'd3;
  dec24_n u_dec (.w(w_idx_nxt), .y(w_dec));
  // Outputs are built from next-state values so they change on the same edge as idx
  assign w_an_nxt = (GUARD_ON && int'(w_cnt_nxt) < GUARD) ? AN_OFF : w_dec;
  always_comb begin
    w_state_nxt = r_state;
    w_pw_nxt = r_pw;
    w_disp_nxt = r_disp;
    w_ack_nxt = 1'b0;
    if (w_fe && (load || r_state == PEND)) begin
      w_disp_nxt = load ? din : r_pw;
      w_ack_nxt = 1'b1;
      w_state_nxt = IDLE;
    end else if (load) begin
      w_pw_nxt = din;
      w_state_nxt = PEND;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_state <= IDLE;
      r_pw <= '0;
      r_disp <= '0;
      r_ack <= 1'b0;
      r_an_n <= AN_RST;
      r_digit <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;
      r_state <= w_state_nxt;
      r_pw <= w_pw_nxt;
      r_disp <= w_disp_nxt;
      r_ack <= w_ack_nxt;
      r_an_n <= w_an_nxt;
      r_digit <= w_disp_nxt[NIB_W*w_idx_nxt +: NIB_W];
    end
  end
  assign ack = r_ack;
  assign an_n = r_an_n;
  assign digit = r_digit;
  assign idx = r_idx;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: table, directed and random checks against a frame-level model
module tb_digit_scan_ctrl;
  localparam int DIV = 4;
  localparam int GUARD = 1;
  localparam int FRAME = 4 * DIV;
  typedef struct {
    logic        load;
    logic [15:0] din;
    logic [1:0]  idx;
    logic [3:0]  an_n;
    logic [3:0]  digit;
    logic        ack;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0;
  logic [15:0] din = '0;
  logic ack, ack1;
  logic [3:0] an_n, an_n1, digit, digit1;
  logic [1:0] idx, idx1;
  int n_cmp = 0;
  int n_err = 0;
  int m_n;
  logic [15:0] m_disp, m_pw;
  bit m_pend, m_ack;
  vec_t tab[5];

  always #5 clk = ~clk;

  digit_scan_ctrl #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .load(load), .din(din),
    .ack(ack), .an_n(an_n), .digit(digit), .idx(idx));

  digit_scan_ctrl #(.DIV(1), .GUARD(0)) dut1 (
    .clk(clk), .rst(rst), .load(load), .din(din),
    .ack(ack1), .an_n(an_n1), .digit(digit1), .idx(idx1));

  function automatic logic [3:0] exp_an(int n, int div, int guard);
    logic [3:0] oh;
    oh = 4'b0001 << ((n / div) % 4);
`ifdef SCAN_GHOST_GUARD_EN
    if (n % div < guard) return 4'b1111;
`endif
    return ~oh;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @n=%0d: got %h want %h", nm, m_n, act, exp);
    end
  endtask

  task automatic check_all();
    int i;
    i = (m_n / DIV) % 4;
    chk("idx", {14'b0, idx}, 16'(i));
    chk("an_n", {12'b0, an_n}, {12'b0, exp_an(m_n, DIV, GUARD)});
    chk("digit", {12'b0, digit}, (m_disp >> (4 * i)) & 16'hF);
    chk("ack", {15'b0, ack}, {15'b0, m_ack});
    chk("idx_div1", {14'b0, idx1}, 16'(m_n % 4));
    chk("an_div1", {12'b0, an_n1}, {12'b0, exp_an(m_n, 1, 0)});
  endtask

  task automatic step(input logic l, input logic [15:0] d);
    bit fe;
    load = l;
    din = d;
    @(posedge clk);
    #1;
    load = 1'b0;
    fe = (m_n % FRAME) == FRAME - 1;
    m_ack = 1'b0;
    if (fe && (l || m_pend)) begin
      m_disp = l ? d : m_pw;
      m_ack = 1'b1;
      m_pend = 1'b0;
    end else if (l) begin
      m_pend = 1'b1;
      m_pw = d;
    end
    m_n++;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_n = 0;
    m_disp = '0;
    m_pw = '0;
    m_pend = 1'b0;
    m_ack = 1'b0;
    chk("rst_ack", {15'b0, ack}, 16'h0);
    chk("rst_digit", {12'b0, digit}, 16'h0);
    check_all();
  endtask

  task automatic wait_ack(input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < FRAME + 1 && !seen; k++) begin
      step(1'b0, 16'h0);
      if (ack) seen = 1'b1;
    end
    chk(nm, {15'b0, seen}, 16'h1);
  endtask

  task automatic show_frame(output logic [15:0] w, output int acks);
    w = '0;
    w[3:0] = digit;
    acks = int'(ack);
    for (int k = 1; k < FRAME; k++) begin
      step(1'b0, 16'h0);
      acks += int'(ack);
      if (k % DIV == 0) w[4 * (k / DIV) +: 4] = digit;
    end
  endtask

  initial begin
    logic [15:0] w;
    int acks;
    tab[0] = '{1'b0, 16'h0, 2'd0, 4'b1110, 4'h0, 1'b0};
    tab[1] = '{1'b0, 16'h0, 2'd1, 4'b1101, 4'h0, 1'b0};
    tab[2] = '{1'b0, 16'h0, 2'd2, 4'b1011, 4'h0, 1'b0};
    tab[3] = '{1'b0, 16'h0, 2'd3, 4'b0111, 4'h0, 1'b0};
    tab[4] = '{1'b0, 16'h0, 2'd0, 4'b1110, 4'h0, 1'b0};
    do_reset();
    foreach (tab[r]) begin
      for (int c = 0; c < DIV; c++) begin
        chk("tab_idx", {14'b0, idx}, {14'b0, tab[r].idx});
`ifndef SCAN_GHOST_GUARD_EN
        chk("tab_an_n", {12'b0, an_n}, {12'b0, tab[r].an_n});
`endif
        chk("tab_digit", {12'b0, digit}, {12'b0, tab[r].digit});
        chk("tab_ack", {15'b0, ack}, {15'b0, tab[r].ack});
        step(tab[r].load, tab[r].din);
      end
    end
    step(1'b1, 16'h4321);
    wait_ack("t2_ack_seen");
    show_frame(w, acks);
    chk("t2_shown", w, 16'h4321);
    chk("t2_acks", 16'(acks), 16'h1);
    step(1'b0, 16'h0);
    step(1'b1, 16'hAAAA);
    step(1'b0, 16'h0);
    step(1'b1, 16'h5678);
    wait_ack("t3_ack_seen");
    show_frame(w, acks);
    chk("t3_shown", w, 16'h5678);
    chk("t3_acks", 16'(acks), 16'h1);
    step(1'b0, 16'h0);
    step(1'b1, 16'h1111);
    for (int k = 0; k < FRAME && (m_n % FRAME) != FRAME - 1; k++) step(1'b0, 16'h0);
    step(1'b1, 16'h9ABC);
    chk("t4_ack", {15'b0, ack}, 16'h1);
    chk("t4_digit0", {12'b0, digit}, 16'hC);
    show_frame(w, acks);
    chk("t4_shown", w, 16'h9ABC);
    chk("t4_acks", 16'(acks), 16'h1);
    acks = 0;
    for (int k = 0; k < FRAME + 2; k++) begin
      step(1'b0, 16'h0);
      acks += int'(ack);
    end
    chk("t4_idle_no_ack", 16'(acks), 16'h0);
    step(1'b1, 16'h7777);
    step(1'b0, 16'h0);
    do_reset();
    acks = 0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      step(1'b0, 16'h0);
      acks += int'(ack);
    end
    chk("t5_no_ack", 16'(acks), 16'h0);
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) == 0, 16'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
